// File: rtl/mem_boot_arbiter.sv
// mem_boot_arbiter: sequences the shared memory port through load, run, halt and dump phases.
module mem_boot_arbiter #(
  parameter logic [31:0] MEM_BYTES      = 32'd400,
  parameter logic [31:0] RUN_MAX_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_wr_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  input  logic        load_done,
  input  logic        dump_req,
  input  logic [31:0] dump_addr,
  output logic [31:0] dump_rdata,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_halt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rst,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state,
  output logic [31:0] run_cycles,
  output logic        timeout,
  output logic        addr_err
);
  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2, DUMP = 2'd3} state_t;
  state_t st, nx;
  logic wr_req, legal, wd_fire;
  assign state     = st;
  assign cpu_stall = (st == HALT) || (st == DUMP);
  assign legal     = (mem_addr[1:0] == 2'b00) && (mem_addr <= MEM_BYTES - 32'd4);
  // rst gates the strobe so an async reset drops writes before the state register updates
  assign mem_wr_en = wr_req && legal && !rst;
  assign wd_fire   = (st == RUN) && !cpu_halt && (run_cycles == RUN_MAX_CYCLES - 32'd1);
  always_comb begin
    nx         = st;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    wr_req     = 1'b0;
    cpu_rdata  = mem_rdata;
    dump_rdata = 32'd0;
    case (st)
      LOAD: begin
        mem_addr  = load_addr;
        mem_wdata = load_wdata;
        wr_req    = load_wr_en;
        cpu_rdata = 32'd0;
        nx        = load_done ? RUN : LOAD;
      end
      RUN: begin
        wr_req = cpu_wr_en;
        nx     = (cpu_halt || wd_fire) ? HALT : RUN;
      end
      HALT: nx = dump_req ? DUMP : HALT;
      DUMP: begin
        mem_addr   = dump_addr;
        cpu_rdata  = 32'd0;
        dump_rdata = mem_rdata;
        nx         = dump_req ? DUMP : HALT;
      end
      default: nx = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= LOAD;
      cpu_rst    <= 1'b1;
      run_cycles <= 32'd0;
      timeout    <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      st      <= nx;
      cpu_rst <= (nx == LOAD);
      if (st == RUN && run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
      if (wd_fire) timeout <= 1'b1;
      if (wr_req && !legal) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_boot_arbiter.sv
// tb_mem_boot_arbiter: randomized boot-flow scenarios checked against a phase-level reference model.
module tb_mem_boot_arbiter;
  localparam logic [31:0] MEM = 32'd400;
  localparam logic [31:0] MAXC = 32'd40;
  logic clk = 1'b0, rst = 1'b1;
  logic load_wr_en = 0, load_done = 0, dump_req = 0, cpu_wr_en = 0, cpu_halt = 0;
  logic [31:0] load_addr = 0, load_wdata = 0, dump_addr = 0, cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
  logic [31:0] dump_rdata, cpu_rdata, mem_addr, mem_wdata, run_cycles;
  logic cpu_rst, cpu_stall, mem_wr_en, timeout, addr_err;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int m_st, lc;
  logic [31:0] m_cnt;
  logic m_to, m_err, m_crst;

  mem_boot_arbiter #(.MEM_BYTES(MEM), .RUN_MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .load_wr_en(load_wr_en), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_done(load_done), .dump_req(dump_req), .dump_addr(dump_addr), .dump_rdata(dump_rdata),
    .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en), .cpu_wdata(cpu_wdata), .cpu_halt(cpu_halt),
    .cpu_rdata(cpu_rdata), .cpu_rst(cpu_rst), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state),
    .run_cycles(run_cycles), .timeout(timeout), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ok_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a <= MEM - 4);
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom % 8)
      0: return 32'd396;
      1: return 32'd400;
      2: return 32'd398;
      3: return $urandom;
      4: return 32'd6;
      default: return ($urandom % 100) * 4;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_to = 0; m_err = 0; m_crst = 1; lc = 0;
  endtask

  task automatic check_all();
    logic [31:0] ea, ed, ecr, edr;
    logic ew;
    ea = (m_st == 0) ? load_addr : (m_st == 3) ? dump_addr : cpu_addr;
    ed = (m_st == 0) ? load_wdata : cpu_wdata;
    ew = rst ? 1'b0 : (m_st == 0) ? load_wr_en && ok_addr(load_addr) :
         (m_st == 1) ? cpu_wr_en && ok_addr(cpu_addr) : 1'b0;
    ecr = (m_st == 0 || m_st == 3) ? 32'd0 : mem_rdata;
    edr = (m_st == 3) ? mem_rdata : 32'd0;
    chk("state", {30'd0, state}, m_st);
    chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_crst});
    chk("cpu_stall", {31'd0, cpu_stall}, (m_st >= 2) ? 32'd1 : 32'd0);
    chk("run_cycles", run_cycles, m_cnt);
    chk("timeout", {31'd0, timeout}, {31'd0, m_to});
    chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, ew});
    chk("mem_addr", mem_addr, ea);
    if (m_st <= 1) chk("mem_wdata", mem_wdata, ed);
    if (m_st != 2) chk("cpu_rdata", cpu_rdata, ecr);
    chk("dump_rdata", dump_rdata, edr);
  endtask

  task automatic model_step();
    int nx;
    nx = m_st;
    if (m_st == 0) begin
      if (load_wr_en && !ok_addr(load_addr)) m_err = 1;
      if (load_done) nx = 1;
      lc++;
    end else if (m_st == 1) begin
      if (cpu_wr_en && !ok_addr(cpu_addr)) m_err = 1;
      if (cpu_halt) nx = 2;
      else if (m_cnt == MAXC - 1) begin m_to = 1; nx = 2; end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (m_st == 2) begin
      if (dump_req) nx = 3;
    end else if (!dump_req) nx = 2;
    m_st = nx;
    m_crst = (nx == 0);
  endtask

  initial begin
    int halt_at, load_len, rst_at;
    model_reset();
    for (int s = 0; s < 24; s++) begin
      halt_at  = (s == 0) ? 37 : (s == 1) ? 40 : (s == 2) ? 0 : int'($urandom_range(0, 60));
      load_len = $urandom_range(1, 8);
      rst_at   = (s % 4 == 3) ? int'($urandom_range(5, 90)) : -1;
      for (int k = 0; k < 120; k++) begin
        @(negedge clk);
        rst = (k == 0) || (k == rst_at);
        load_wr_en = $urandom % 2;
        load_addr  = rnd_addr();
        load_wdata = $urandom;
        cpu_wr_en  = $urandom % 2;
        cpu_addr   = rnd_addr();
        cpu_wdata  = $urandom;
        dump_addr  = ($urandom % 100) * 4;
        mem_rdata  = $urandom;
        dump_req   = ($urandom % 3) != 0;
        if (rst) begin
          load_wr_en = 1'b1;
          load_addr  = 32'd0;
          model_reset();
        end
        load_done = (lc >= load_len);
        cpu_halt  = (halt_at != 0) && (m_cnt >= halt_at - 1);
        #1;
        check_all();
        if (!rst) model_step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
Sequences the shared instruction/data memory port through the board's boot flow: UART load, CPU run, halt, UART dump. Multiplexes one single-port memory between the UART loader/dumper and the pipelined CPU, and holds the CPU in reset or stall outside its run window. A run-cycle watchdog and an address checker protect the memory. Sits between the UART memory bridge, the CPU core and the memory macro.

Parameters:
MEM_BYTES, 32'd400, memory size in bytes; valid word addresses are 0 to MEM_BYTES-4.
RUN_MAX_CYCLES, 32'd1000000, watchdog limit on cycles spent in RUN.

Ports:
clk  in  1  system clock, 100MHz
rst  in  1  asynchronous, active-high reset
load_wr_en  in  1  loader write strobe, one cycle per word
load_addr  in  32  loader byte address
load_wdata  in  32  loader write data
load_done  in  1  loader finished (level, sticky in loader)
dump_req  in  1  dump enable (switch level)
dump_addr  in  32  dumper read address
dump_rdata  out  32  read data to dumper
cpu_addr  in  32  CPU data/instruction address
cpu_wr_en  in  1  CPU write strobe
cpu_wdata  in  32  CPU write data
cpu_halt  in  1  CPU reached halt (level)
cpu_rdata  out  32  read data to CPU
cpu_rst  out  1  CPU reset, active-high
cpu_stall  out  1  CPU pipeline freeze
mem_addr  out  32  memory address
mem_wr_en  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
state  out  2  0=LOAD 1=RUN 2=HALT 3=DUMP (LED debug)
run_cycles  out  32  cycles spent in RUN, saturating
timeout  out  1  sticky, watchdog fired
addr_err  out  1  sticky, illegal write attempted

Behaviour:
- Reset values: state=LOAD, cpu_rst=1, cpu_stall=0, run_cycles=0, timeout=0, addr_err=0. On reset, mem_wr_en is 0 immediately (combinational from state and inputs).
- A reset asserted mid-operation returns to LOAD from any state. There is no other path back to LOAD.
- LOAD:
  - mem_addr=load_addr, mem_wdata=load_wdata, mem_wr_en=load_wr_en & legal.
  - cpu_rst=1. cpu_rdata=0, dump_rdata=0.
  - If load_done=1, go to RUN next cycle. A write strobed in the same cycle as load_done is still performed.
- RUN:
  - mem_* driven from cpu_*; mem_wr_en=cpu_wr_en & legal. cpu_rdata=mem_rdata.
  - cpu_rst is a register and deasserts on the first RUN cycle. cpu_stall=0.
  - run_cycles increments by 1 each RUN cycle and saturates at 32'hFFFFFFFF.
  - If cpu_halt=1, go to HALT.
  - Else if run_cycles==RUN_MAX_CYCLES-1, set timeout=1 and go to HALT. If both hold in the same cycle, cpu_halt wins and timeout stays 0.
- HALT:
  - cpu_stall=1. mem_addr=cpu_addr, mem_wr_en=0 (CPU writes dropped, not errors). run_cycles frozen.
  - If dump_req=1, go to DUMP.
- DUMP:
  - cpu_stall=1. mem_addr=dump_addr, mem_wr_en=0, dump_rdata=mem_rdata. cpu_rdata=0.
  - If dump_req=0, go to HALT. Repeat dumps are allowed.
- Outside DUMP, dump_rdata=0.
- Legality rule: a write is legal only when addr[1:0]==2'b00 and addr <= MEM_BYTES-4 (unsigned 32-bit compare).
  - An illegal enabled write is suppressed (mem_wr_en=0) and sets addr_err the next cycle.
  - addr_err and timeout clear only on rst.
- Read data is combinational pass-through of mem_rdata; the memory's own read latency is unchanged by this block.
- Datapath muxing is combinational on the state register. All state, counters and flags are registered on posedge clk.

Test Plan:
1. Reset, then loader writes 0x20080005 @0 and 0x00000000 @4, then load_done=1 -> mem_wr_en pulses twice with matching addr/data; cpu_rst=1 until the cycle after load_done, then state=1.
2. In RUN, cpu_wr_en=1, cpu_addr=8, cpu_wdata=0xDEADBEEF -> mem_wr_en=1 with those values. Next, cpu_addr=6 write -> mem_wr_en=0, addr_err=1 next cycle.
3. cpu_halt after 37 RUN cycles -> state=2, cpu_stall=1, run_cycles=37 and holds; a CPU write in HALT gives mem_wr_en=0 and addr_err unchanged.
4. RUN_MAX_CYCLES=16, cpu_halt never asserted -> after 16 RUN cycles state=2, timeout=1, run_cycles=16.
5. From HALT, dump_req=1 with dump_addr=0 and mem_rdata=0x20080005 -> state=3, dump_rdata=0x20080005, cpu_rdata=0. dump_req=0 -> state=2. dump_req=1 again -> state=3.
6. rst asserted mid-DUMP -> state=0, cpu_rst=1, flags and run_cycles cleared, mem_wr_en=0.
